// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit-side arbitration blocks:
// arbiter state encoding, data width and timeout counter width.
package uart_pkg;

    localparam int UART_DATA_W = 8;
    localparam int TMO_CNT_W   = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OPEN  = 2'd1,
        ISSUE = 2'd2,
        HOLD  = 2'd3
    } arb_state_t;

    // Port index 'offset' positions after 'base', wrapping modulo 'nports'.
    function automatic int rr_wrap(input int base, input int offset, input int nports);
        return (base + offset) % nports;
    endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker. The search starts one position after
// 'ptr' (the last served index) and wraps, so the most recently served
// requester has the lowest priority. Usable by any shared-resource arbiter.
module uart_rr_pick
    import uart_pkg::*;
#(
    parameter int NPORTS = 4,
    parameter int IDX_W  = $clog2(NPORTS)
) (
    input  logic [NPORTS-1:0] req,
    input  logic [IDX_W-1:0]  ptr,
    output logic [NPORTS-1:0] pick,
    output logic [IDX_W-1:0]  pick_idx,
    output logic              pick_any
);

    logic found_s;
    int   cand_s;

    // Walk the ports starting just after the pointer; the first requester wins.
    always_comb begin
        pick     = '0;
        pick_idx = '0;
        found_s  = 1'b0;
        cand_s   = 0;
        for (int k = 1; k <= NPORTS; k++) begin
            cand_s = rr_wrap(int'(ptr), k, NPORTS);
            if (!found_s && req[cand_s]) begin
                found_s        = 1'b1;
                pick[cand_s]   = 1'b1;
                pick_idx       = IDX_W'(cand_s);
            end else begin
                // an earlier candidate already won, or this one is not requesting
                found_s = found_s;
            end
        end
    end

    // Any request at all; lets the caller decide whether a pick is meaningful.
    always_comb begin
        pick_any = |req;
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between NPORTS byte-stream clients.
// A client owns the transmitter for a whole message (until a byte tagged
// 'last' is sent, or until the owner idles for TIMEOUT cycles), so messages
// from different clients never interleave on the line.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NPORTS  = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NPORTS-1:0]           in_valid,
    input  logic [UART_DATA_W*NPORTS-1:0] in_data,
    input  logic [NPORTS-1:0]           in_last,
    output logic [NPORTS-1:0]           in_ready,
    output logic [NPORTS-1:0]           grant,
    output logic [UART_DATA_W-1:0]      uart_wdata,
    output logic                        uart_we,
    input  logic                        uart_busy,
    output logic                        timeout
);

    localparam int                    IDX_W     = $clog2(NPORTS);
    localparam logic [IDX_W-1:0]      PTR_RST   = IDX_W'(NPORTS - 1);
    localparam logic [TMO_CNT_W-1:0]  TMO_LIMIT = TMO_CNT_W'(TIMEOUT);
    localparam logic [TMO_CNT_W-1:0]  CNT_MAX   = '1;
    localparam logic                  TMO_EN    = (TIMEOUT != 0);

    arb_state_t              state_r;
    arb_state_t              state_nxt_s;
    logic [NPORTS-1:0]       grant_r;
    logic [IDX_W-1:0]        gidx_r;
    logic [IDX_W-1:0]        ptr_r;
    logic                    last_r;
    logic [UART_DATA_W-1:0]  wdata_r;
    logic                    we_r;
    logic [TMO_CNT_W-1:0]    cnt_r;

    logic [NPORTS-1:0]       pick_s;
    logic [IDX_W-1:0]        pick_idx_s;
    logic                    pick_any_s;
    logic                    owner_valid_s;
    logic                    owner_last_s;
    logic [UART_DATA_W-1:0]  owner_data_s;
    logic                    accept_s;
    logic                    idle_tick_s;
    logic                    expire_s;
    logic                    release_s;
    logic                    open_entry_s;

    uart_rr_pick #(
        .NPORTS (NPORTS),
        .IDX_W  (IDX_W)
    ) u_pick (
        .req      (in_valid),
        .ptr      (ptr_r),
        .pick     (pick_s),
        .pick_idx (pick_idx_s),
        .pick_any (pick_any_s)
    );

    // Owner's lane of the client bus, selected by the registered grant index.
    always_comb begin
        owner_valid_s = in_valid[gidx_r];
        owner_last_s  = in_last[gidx_r];
        owner_data_s  = in_data[{gidx_r, 3'b000} +: UART_DATA_W];
    end

    // Handshake and timeout qualifiers shared by the FSM and the datapath.
    always_comb begin
        accept_s     = |(in_valid & in_ready);
        idle_tick_s  = (state_r == OPEN) && !uart_busy && !owner_valid_s;
        // an accept in the expiry cycle keeps the grant alive
        expire_s     = TMO_EN && (state_r == OPEN) && (cnt_r == TMO_LIMIT) && !accept_s;
        release_s    = ((state_r == HOLD) && last_r) || expire_s;
        open_entry_s = (state_nxt_s == OPEN) && (state_r != OPEN);
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (pick_any_s) begin
                    state_nxt_s = OPEN;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            OPEN: begin
                if (accept_s) begin
                    state_nxt_s = ISSUE;
                end else if (expire_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = OPEN;
                end
            end
            ISSUE: begin
                state_nxt_s = HOLD;
            end
            HOLD: begin
                // this cycle covers the transmitter's lag before busy rises
                if (last_r) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = OPEN;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // FSM outputs: ready follows the owner's grant bit gated only by busy.
    always_comb begin
        in_ready = '0;
        timeout  = 1'b0;
        if ((state_r == OPEN) && !uart_busy) begin
            in_ready = grant_r;
        end else begin
            in_ready = '0;
        end
        timeout = expire_s;
    end

    // Grant ownership and round-robin pointer (last served index).
    always_ff @(posedge clk) begin
        if (reset) begin
            grant_r <= '0;
            gidx_r  <= '0;
            ptr_r   <= PTR_RST;
        end else if ((state_r == IDLE) && pick_any_s) begin
            grant_r <= pick_s;
            gidx_r  <= pick_idx_s;
        end else if (release_s) begin
            grant_r <= '0;
            ptr_r   <= gidx_r;
        end else begin
            grant_r <= grant_r;
        end
    end

    // Byte capture on accept and the one-cycle write strobe to the transmitter.
    always_ff @(posedge clk) begin
        if (reset) begin
            wdata_r <= '0;
            last_r  <= 1'b0;
            we_r    <= 1'b0;
        end else begin
            we_r <= accept_s;
            if (accept_s) begin
                wdata_r <= owner_data_s;
                last_r  <= owner_last_s;
            end else begin
                wdata_r <= wdata_r;
            end
        end
    end

    // Owner idle counter: restarts on OPEN entry and on each accept, saturates.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r <= '0;
        end else if (open_entry_s || accept_s) begin
            cnt_r <= '0;
        end else if (idle_tick_s && (cnt_r != CNT_MAX)) begin
            cnt_r <= cnt_r + 16'd1;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Registered values driven straight onto the ports.
    always_comb begin
        grant      = grant_r;
        uart_wdata = wdata_r;
        uart_we    = we_r;
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed and randomized bench for uart_tx_arbiter. A simple transmitter
// model raises busy for tx_len cycles per write; client models present queued
// bytes; a round-robin message-order model predicts the byte stream.
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int TO = 16;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [N-1:0]   in_valid = '0;
    logic [8*N-1:0] in_data = '0;
    logic [N-1:0]   in_last = '0;
    logic [N-1:0]   in_ready;
    logic [N-1:0]   grant;
    logic [7:0]     uart_wdata;
    logic           uart_we;
    logic           uart_busy = 1'b0;
    logic           timeout;

    logic [N-1:0]   in_ready_nto;
    logic [N-1:0]   grant_nto;
    logic [7:0]     wdata_nto;
    logic           we_nto;
    logic           timeout_nto;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.NPORTS(N), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_last(in_last), .in_ready(in_ready), .grant(grant),
        .uart_wdata(uart_wdata), .uart_we(uart_we), .uart_busy(uart_busy),
        .timeout(timeout)
    );

    uart_tx_arbiter #(.NPORTS(N), .TIMEOUT(0)) dut_nto (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_last(in_last), .in_ready(in_ready_nto), .grant(grant_nto),
        .uart_wdata(wdata_nto), .uart_we(we_nto), .uart_busy(uart_busy),
        .timeout(timeout_nto)
    );

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [7:0] bd [N][64];
    logic       bl [N][64];
    int         hd [N];
    int         tl [N];
    logic [N-1:0] en = '1;
    logic       force_busy = 1'b0;
    int         tx_left = 0;
    int         tx_len  = 10;
    logic [N-1:0] acc = '0;

    logic [7:0]   lg_d [512];
    logic [N-1:0] lg_g [512];
    int           lg_t [512];
    int           lg_n = 0;
    int           to_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit pending();
        for (int p = 0; p < N; p++) begin
            if (hd[p] < tl[p]) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic push(input int p, input logic [7:0] d, input logic l);
        bd[p][tl[p]] = d;
        bl[p][tl[p]] = l;
        tl[p]++;
    endtask

    // Present client heads and transmitter busy; note which ports will be accepted.
    task automatic drive();
        for (int p = 0; p < N; p++) begin
            if (hd[p] < tl[p] && en[p]) begin
                in_valid[p]        = 1'b1;
                in_data[p*8 +: 8]  = bd[p][hd[p]];
                in_last[p]         = bl[p][hd[p]];
            end else begin
                in_valid[p]        = 1'b0;
                in_data[p*8 +: 8]  = 8'($urandom);
                in_last[p]         = 1'($urandom);
            end
        end
        uart_busy = force_busy || (tx_left != 0);
        #1;
        acc = in_valid & in_ready;
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        #1;
        for (int p = 0; p < N; p++) begin
            if (acc[p]) hd[p]++;
        end
        if (uart_we === 1'b1) begin
            if (lg_n < 512) begin
                lg_d[lg_n] = uart_wdata;
                lg_g[lg_n] = grant;
                lg_t[lg_n] = cyc;
                lg_n++;
            end
            tx_left = tx_len;
        end else if (tx_left != 0) begin
            tx_left--;
        end
        if (timeout === 1'b1) to_cnt++;
        drive();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        for (int p = 0; p < N; p++) begin hd[p] = 0; tl[p] = 0; end
        en = '1;
        force_busy = 1'b0;
        tx_left = 0;
        drive();
        step();
        step();
        reset = 1'b0;
        drive();
        lg_n = 0;
        to_cnt = 0;
    endtask

    task automatic drain(input string tag, input int budget);
        int k = 0;
        while ((pending() || grant !== '0 || tx_left != 0) && k < budget) begin
            step();
            k++;
        end
        chk(tag, 32'(k < budget), 32'd1);
    endtask

    task automatic wait_we(input string tag, input int budget);
        int k = 0;
        while (uart_we !== 1'b1 && k < budget) begin
            step();
            k++;
        end
        chk(tag, 32'(k < budget), 32'd1);
    endtask

    task automatic chk_log(input string tag, input int i, input logic [7:0] d, input logic [N-1:0] g);
        chk($sformatf("%s_d%0d", tag, i), 32'(lg_d[i]), 32'(d));
        chk($sformatf("%s_g%0d", tag, i), 32'(lg_g[i]), 32'(g));
    endtask

    initial begin
        int w;
        int last_p;
        int ne;
        logic [7:0]   ed [64];
        logic [N-1:0] eg [64];
        logic [N-1:0] mask;
        int len;
        logic [7:0] d;

        // ---- reset values ----
        do_reset();
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd0);
        chk("rst_we", 32'(uart_we), 32'd0);
        chk("rst_wdata", 32'(uart_wdata), 32'd0);
        chk("rst_timeout", 32'(timeout), 32'd0);

        // ---- single client, two-byte message ----
        push(0, 8'h41, 1'b0);
        push(0, 8'h42, 1'b1);
        drive();
        step();
        chk("t1_grant_lat", 32'(grant), 32'h1);
        chk("t1_ready_lat", 32'(in_ready), 32'h1);
        step();
        chk("t1_we_lat", 32'(uart_we), 32'd1);
        chk("t1_wdata_lat", 32'(uart_wdata), 32'h41);
        step();
        chk("t1_we_pulse", 32'(uart_we), 32'd0);
        chk("t1_grant_hold", 32'(grant), 32'h1);
        drain("t1_drain", 200);
        chk("t1_count", 32'(lg_n), 32'd2);
        chk_log("t1", 0, 8'h41, 4'b0001);
        chk_log("t1", 1, 8'h42, 4'b0001);
        chk("t1_gap", 32'((lg_t[1] - lg_t[0]) >= 3), 32'd1);
        chk("t1_idle_grant", 32'(grant), 32'd0);

        // ---- contention from reset, then all four ----
        do_reset();
        push(1, 8'h11, 1'b0); push(1, 8'h12, 1'b0); push(1, 8'h13, 1'b1);
        push(2, 8'h21, 1'b0); push(2, 8'h22, 1'b1);
        drive();
        drain("t2a_drain", 400);
        chk("t2a_count", 32'(lg_n), 32'd5);
        chk_log("t2a", 0, 8'h11, 4'b0010);
        chk_log("t2a", 1, 8'h12, 4'b0010);
        chk_log("t2a", 2, 8'h13, 4'b0010);
        chk_log("t2a", 3, 8'h21, 4'b0100);
        chk_log("t2a", 4, 8'h22, 4'b0100);
        lg_n = 0;
        push(0, 8'h30, 1'b1); push(1, 8'h31, 1'b1);
        push(2, 8'h32, 1'b1); push(3, 8'h33, 1'b1);
        drive();
        drain("t2b_drain", 400);
        chk("t2b_count", 32'(lg_n), 32'd4);
        chk_log("t2b", 0, 8'h33, 4'b1000);
        chk_log("t2b", 1, 8'h30, 4'b0001);
        chk_log("t2b", 2, 8'h31, 4'b0010);
        chk_log("t2b", 3, 8'h32, 4'b0100);

        // ---- interleave guard ----
        do_reset();
        push(0, 8'hA0, 1'b0); push(0, 8'hA1, 1'b0); push(0, 8'hA2, 1'b1);
        push(3, 8'hD3, 1'b1);
        drive();
        wait_we("t3_first_we", 30);
        en[0] = 1'b0;
        drive();
        for (int i = 0; i < 10; i++) begin
            step();
            chk("t3_grant_kept", 32'(grant), 32'h1);
            chk("t3_no_ready3", 32'(in_ready[3]), 32'd0);
        end
        en[0] = 1'b1;
        drive();
        drain("t3_drain", 400);
        chk("t3_count", 32'(lg_n), 32'd4);
        chk_log("t3", 0, 8'hA0, 4'b0001);
        chk_log("t3", 1, 8'hA1, 4'b0001);
        chk_log("t3", 2, 8'hA2, 4'b0001);
        chk_log("t3", 3, 8'hD3, 4'b1000);
        chk("t3_no_timeout", 32'(to_cnt), 32'd0);

        // ---- busy pacing ----
        do_reset();
        force_busy = 1'b1;
        push(1, 8'h5A, 1'b1);
        drive();
        step();
        chk("t4_grant", 32'(grant), 32'h2);
        for (int i = 0; i < 50; i++) begin
            step();
            chk("t4_ready_low", 32'(in_ready), 32'd0);
            chk("t4_we_low", 32'(uart_we), 32'd0);
        end
        force_busy = 1'b0;
        drive();
        chk("t4_ready_fall", 32'(in_ready), 32'h2);
        step();
        chk("t4_we", 32'(uart_we), 32'd1);
        chk("t4_wdata", 32'(uart_wdata), 32'h5A);
        drain("t4_drain", 200);

        // ---- reset in ISSUE ----
        do_reset();
        push(2, 8'h77, 1'b0); push(2, 8'h78, 1'b1);
        drive();
        wait_we("t5_we", 30);
        w = cyc;
        reset = 1'b1;
        drive();
        step();
        chk("t5_we", 32'(uart_we), 32'd0);
        chk("t5_grant", 32'(grant), 32'd0);
        chk("t5_ready", 32'(in_ready), 32'd0);
        chk("t5_timeout", 32'(timeout), 32'd0);
        reset = 1'b0;
        for (int p = 0; p < N; p++) begin hd[p] = 0; tl[p] = 0; end
        lg_n = 0;
        push(0, 8'h60, 1'b1); push(1, 8'h61, 1'b1);
        push(2, 8'h62, 1'b1); push(3, 8'h63, 1'b1);
        drive();
        step();
        chk("t5_regrant", 32'(grant), 32'h1);
        chk("t5_ready_busy", 32'(in_ready), uart_busy ? 32'd0 : 32'h1);
        drain("t5_drain", 400);
        chk("t5_count", 32'(lg_n), 32'd4);
        chk_log("t5", 0, 8'h60, 4'b0001);
        chk_log("t5", 3, 8'h63, 4'b1000);
        chk("t5_first_we_cycle", 32'(lg_t[0]), 32'(w + tx_len + 1));

        // ---- timeout (TIMEOUT=16 vs disabled) ----
        do_reset();
        push(2, 8'h99, 1'b0);
        drive();
        wait_we("t6_we", 30);
        w = cyc;
        for (int i = 0; i < tx_len + TO + 6; i++) begin
            step();
            chk("t6_timeout", 32'(timeout), 32'(cyc == w + tx_len + TO));
            chk("t6_grant", 32'(grant), (cyc <= w + tx_len + TO) ? 32'h4 : 32'd0);
            chk("t6_nto_grant", 32'(grant_nto), 32'h4);
            chk("t6_nto_timeout", 32'(timeout_nto), 32'd0);
            chk("t6_nto_we", 32'(we_nto), 32'd0);
            chk("t6_nto_ready", 32'(in_ready_nto), (cyc >= w + tx_len) ? 32'h4 : 32'd0);
        end
        chk("t6_nto_wdata", 32'(wdata_nto), 32'h99);
        chk("t6_pulses", 32'(to_cnt), 32'd1);

        // ---- randomized rounds against a message-order model ----
        do_reset();
        last_p = N - 1;
        for (int r = 0; r < 12; r++) begin
            lg_n = 0;
            ne = 0;
            tx_len = $urandom_range(3, 12);
            mask = N'($urandom_range(1, (1 << N) - 1));
            for (int k = 1; k <= N; k++) begin
                int p;
                p = (last_p + k) % N;
                if (mask[p]) begin
                    len = $urandom_range(1, 4);
                    for (int b = 0; b < len; b++) begin
                        d = 8'($urandom);
                        push(p, d, b == len - 1);
                        ed[ne] = d;
                        eg[ne] = N'(1 << p);
                        ne++;
                    end
                end
            end
            for (int k = 1; k <= N; k++) begin
                if (mask[(last_p + k) % N]) w = (last_p + k) % N;
            end
            last_p = w;
            drive();
            drain($sformatf("rnd%0d_drain", r), 1500);
            chk($sformatf("rnd%0d_count", r), 32'(lg_n), 32'(ne));
            for (int i = 0; i < ne; i++) begin
                chk_log($sformatf("rnd%0d", r), i, ed[i], eg[i]);
            end
            chk($sformatf("rnd%0d_no_timeout", r), 32'(to_cnt), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares one `uart` transmitter between `NPORTS` byte-stream clients, such as a console, debug monitor and trace. Each client offers bytes on a valid/ready handshake. The arbiter grants the transmitter to one client per message and holds the grant until that client marks the final byte with `last`, so messages never interleave. It drives the transmitter's `we`/`wdata` and paces bytes on the transmitter's `busy`.

## Interface
- `NPORTS`, default 4: number of clients, legal range 2..8.
- `TIMEOUT`, default 1024: idle cycles in OPEN before the grant is forcibly released; 0 disables the timeout; 16-bit counter.
- `clk`  in  1  system clock; all logic on posedge.
- `reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  NPORTS  client i has a byte.
- `in_data`  in  8*NPORTS  client i byte at bits [8i+7:8i].
- `in_last`  in  NPORTS  byte is the last of the message.
- `in_ready`  out  NPORTS  byte accepted when `in_valid[i] & in_ready[i]`.
- `grant`  out  NPORTS  one-hot owner; zero when idle.
- `uart_wdata`  out  8  to transmitter `wdata`.
- `uart_we`  out  1  to transmitter `we`; single-cycle pulse.
- `uart_busy`  in  1  from transmitter `busy`.
- `timeout`  out  1  one-cycle pulse when a grant is force-released.

## Operation
- States:
  - IDLE: `grant` = 0. If any `in_valid`, the round-robin pick is registered into `grant` and the state moves to OPEN.
  - OPEN: `in_ready[g] = in_valid[g]`-independent, equal to `!uart_busy`; all other ready bits are 0.
    - On accept: latch the byte into `uart_wdata`, latch `in_last` into `last_q`, move to ISSUE.
  - ISSUE: `uart_we` = 1 for exactly this cycle; move to HOLD.
  - HOLD: one cycle, covering the transmitter's one-cycle lag before `busy` rises.
    - Next state is IDLE if `last_q`, otherwise OPEN.
    - On leaving to IDLE, update the round-robin pointer and clear `grant`.
- Round robin:
  - Pointer holds the last granted index. Search starts at pointer+1 and wraps modulo NPORTS.
  - Reset pointer = NPORTS-1, so port 0 has first priority.
- Timeout:
  - The counter clears on entry to OPEN and on every accept.
  - It increments each OPEN cycle where `!uart_busy & !in_valid[g]`.
  - When it reaches `TIMEOUT` (nonzero): pulse `timeout`, go to IDLE, update the pointer. The owner is treated as if it had sent `last`.
- Bytes from a client without a grant are never accepted. A client's `in_valid` may drop between bytes without losing the grant, until timeout.
- `in_data`/`in_last` are sampled only on the accept cycle.

## Timing
- Reset values: `grant` = 0, `in_ready` = 0, `uart_we` = 0, `uart_wdata` = 8'h00, `timeout` = 0. State IDLE, counter 0, pointer NPORTS-1.
- Request to grant: `in_valid` high at cycle T in IDLE gives `grant` at T+1 and `in_ready` at T+1 if `!uart_busy`.
- Accept at T gives `uart_we` = 1 at T+1 with `uart_wdata` valid. `uart_busy` is expected high by T+2 (HOLD). OPEN resumes at T+3, and ready is gated by `uart_busy`.
- Minimum 3 cycles between accepts; in practice the rate is set by the transmitter's bit rate.
- Simultaneous requests in IDLE: exactly one grant, chosen by the pointer.
- `in_valid` asserted by a non-owner during a message: it waits; it is served next if first in round-robin order after the owner.
- Timeout and accept in the same cycle: the accept wins and the counter clears.
- Reset mid-message:
  - All outputs return to reset values next cycle. A byte already handed to the transmitter finishes on the line.
  - The first post-reset accept waits for `uart_busy` low.
- No combinational path from `uart_busy` to `uart_we`. `in_ready` is combinational from state, `grant` and `uart_busy` only, never from `in_valid`.

## Structure
- Shared package `uart_pkg`:
  - State encoding: IDLE=2'd0, OPEN=2'd1, ISSUE=2'd2, HOLD=2'd3.
  - `UART_DATA_W` = 8.
  - Timeout counter width = 16.
- Sub-module `uart_rr_pick`: combinational round-robin picker.
  - Inputs: `req[NPORTS]`, `ptr`.
  - Outputs: one-hot `pick` and its index.
  - Reusable by later shared-resource arbiters.

## Test plan
- Single client: port 0 sends 8'h41 (`last`=0) then 8'h42 (`last`=1). Two `uart_we` pulses with wdata 41, 42 in order, each 3+ cycles apart. `grant` = 4'b0001 throughout, then 0.
- Contention: ports 1 and 2 request simultaneously from reset. Port 1 is served fully (3-byte message), then port 2. Next, all four request and the order is 3, 0, 1, 2.
- Interleave guard: port 0 mid-message drops `in_valid` for 10 cycles while port 3 requests. Port 3 gets no `in_ready`, and port 0's remaining bytes follow with no port 3 byte between them.
- Timeout: `TIMEOUT` = 16, port 2 sends one non-last byte then idles. `timeout` pulses once after 16 idle cycles past transmitter completion, and `grant` goes to 0 the next cycle. With `TIMEOUT` = 0 the grant is never released.
- Busy pacing: hold `uart_busy` high externally for 50 cycles while in OPEN. `in_ready` stays 0 and `uart_we` stays 0. The byte is accepted the first cycle `uart_busy` falls.
- Reset mid-operation: assert `reset` in ISSUE. The next cycle has `uart_we` = 0, `grant` = 0, `in_ready` = 0, and a re-request grants port 0 first.
